// File: rtl/lcd_pcf8574_sequencer.sv
// HD44780 4-bit sequencer feeding a PCF8574 backpack through an I2C master.
// Runs the power-on init, then turns accepted command/data bytes into four
// expander writes (hi/EN1, hi/EN0, lo/EN1, lo/EN0) with execution delays.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_PWRUP | count the power-up wait after reset
// S_ISSUE | expander byte ready on i2c_data, start as soon as master idle
// S_WAIT  | transfer in flight, wait for i2c_done
// S_DELAY | HD44780 execution delay after a nibble/byte unit
// S_IDLE  | init complete, accepting a byte from upstream
module lcd_pcf8574_sequencer #(
  parameter logic BACKLIGHT   = 1'b1,
  parameter int   T_POWERUP   = 2_000_000,
  parameter int   T_INIT_LONG = 205_000,
  parameter int   T_SHORT     = 5_000,
  parameter int   T_CMD       = 2_000,
  parameter int   T_CLEAR     = 80_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       i2c_start,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  output logic       init_done
);

  localparam int MAX_A = (T_POWERUP > T_INIT_LONG) ? T_POWERUP : T_INIT_LONG;
  localparam int MAX_B = (T_SHORT > T_CMD) ? T_SHORT : T_CMD;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_D = (MAX_C > T_CLEAR) ? MAX_C : T_CLEAR;
  localparam int CW    = $clog2(MAX_D) + 1;

  // S_DELAY runs from the loaded value down to zero inclusive, so load T-1
  // to spend exactly T cycles there; a zero delay still costs one cycle.
  localparam logic [CW-1:0] LD_LONG  = CW'((T_INIT_LONG > 0) ? T_INIT_LONG - 1 : 0);
  localparam logic [CW-1:0] LD_SHORT = CW'((T_SHORT > 0) ? T_SHORT - 1 : 0);
  localparam logic [CW-1:0] LD_CMD   = CW'((T_CMD > 0) ? T_CMD - 1 : 0);
  localparam logic [CW-1:0] LD_CLEAR = CW'((T_CLEAR > 0) ? T_CLEAR - 1 : 0);
  localparam logic [CW-1:0] PWR_LAST = CW'((T_POWERUP > 0) ? T_POWERUP - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {S_PWRUP, S_ISSUE, S_WAIT, S_DELAY, S_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    step_q, step_d;
  logic [1:0]    widx_q, widx_d;
  logic          rs_q, rs_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    i2c_data_q, i2c_data_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          init_done_q, init_done_d;

  logic [1:0]    last_widx;
  logic          is_clear;

  // widx bit1 selects the low nibble, bit0 clears EN for the falling strobe
  function automatic logic [7:0] exp_byte(input logic rs, input logic [7:0] data,
                                          input logic [1:0] widx);
    logic [3:0] nib;
    nib = widx[1] ? data[3:0] : data[7:4];
    return {nib, BACKLIGHT, ~widx[0], 1'b0, rs};
  endfunction

  // steps 0..3 are bare high nibbles (the low nibble is never sent)
  function automatic logic [7:0] init_byte(input logic [2:0] step);
    logic [7:0] b;
    case (step)
      3'd0, 3'd1, 3'd2: b = 8'h30;
      3'd3:             b = 8'h20;
      3'd4:             b = 8'h28;
      3'd5:             b = 8'h0C;
      3'd6:             b = 8'h01;
      default:          b = 8'h06;
    endcase
    return b;
  endfunction

  function automatic logic [CW-1:0] init_delay(input logic [2:0] step);
    logic [CW-1:0] d;
    case (step)
      3'd0:       d = LD_LONG;
      3'd1, 3'd2: d = LD_SHORT;
      3'd6:       d = LD_CLEAR;
      default:    d = LD_CMD;
    endcase
    return d;
  endfunction

  // per-unit helpers: nibble units stop after two writes; clear/home are slow
  always_comb begin
    last_widx = (!init_done_q && (step_q < 3'd4)) ? 2'd1 : 2'd3;
    is_clear  = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02) || (byte_q == 8'h03));
  end

  // next-state and next-output computation for the sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    widx_d      = widx_q;
    rs_d        = rs_q;
    byte_d      = byte_q;
    i2c_data_d  = i2c_data_q;
    init_done_d = init_done_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q >= PWR_LAST) begin
          cnt_d      = '0;
          step_d     = 3'd0;
          widx_d     = 2'd0;
          rs_d       = 1'b0;
          byte_d     = init_byte(3'd0);
          i2c_data_d = exp_byte(1'b0, init_byte(3'd0), 2'd0);
          state_d    = S_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ISSUE: begin
        if (!i2c_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_done) begin
          if (widx_q != last_widx) begin
            widx_d     = widx_q + 2'd1;
            i2c_data_d = exp_byte(rs_q, byte_q, widx_q + 2'd1);
            state_d    = S_ISSUE;
          end else begin
            if (!init_done_q) cnt_d = init_delay(step_q);
            else              cnt_d = is_clear ? LD_CLEAR : LD_CMD;
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (step_q == 3'd7) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            step_d     = step_q + 3'd1;
            widx_d     = 2'd0;
            rs_d       = 1'b0;
            byte_d     = init_byte(step_q + 3'd1);
            i2c_data_d = exp_byte(1'b0, init_byte(step_q + 3'd1), 2'd0);
            state_d    = S_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rs_d       = cmd_rs;
          byte_d     = cmd_data;
          widx_d     = 2'd0;
          i2c_data_d = exp_byte(cmd_rs, cmd_data, 2'd0);
          state_d    = S_ISSUE;
        end
      end
      default: state_d = S_PWRUP;
    endcase
    cmd_ready_d = (state_d == S_IDLE) && init_done_d;
  end

  // sequencer registers; reset restarts the whole power-up sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      step_q      <= 3'd0;
      widx_q      <= 2'd0;
      rs_q        <= 1'b0;
      byte_q      <= 8'h00;
      i2c_data_q  <= 8'h00;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      widx_q      <= widx_d;
      rs_q        <= rs_d;
      byte_q      <= byte_d;
      i2c_data_q  <= i2c_data_d;
      cmd_ready_q <= cmd_ready_d;
      init_done_q <= init_done_d;
    end
  end

  // start is gated combinationally by busy so it fires in the first idle cycle
  assign i2c_start = (state_q == S_ISSUE) && !i2c_busy;
  assign i2c_data  = i2c_data_q;
  assign cmd_ready = cmd_ready_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_pcf8574_sequencer.sv
// Directed bench for lcd_pcf8574_sequencer with a simple I2C master model
// (busy 6 cycles after a start, then a one-cycle done pulse).
module tb_lcd_pcf8574_sequencer;

  localparam int TP  = 20;
  localparam int TL  = 10;
  localparam int TS  = 5;
  localparam int TC  = 3;
  localparam int TCL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       i2c_busy = 1'b0;
  logic       i2c_done = 1'b0;
  logic       cmd_ready;
  logic       i2c_start;
  logic [7:0] i2c_data;
  logic       init_done;

  lcd_pcf8574_sequencer #(
    .BACKLIGHT(1'b1), .T_POWERUP(TP), .T_INIT_LONG(TL),
    .T_SHORT(TS), .T_CMD(TC), .T_CLEAR(TCL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .i2c_start(i2c_start),
    .i2c_data(i2c_data), .i2c_busy(i2c_busy), .i2c_done(i2c_done),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [7:0] b0, b1, b2, b3;
    int         gap;
  } vec_t;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  int sq[$];
  int dq[$];
  int pend = 0;
  int bcnt = 0;
  bit hold_busy = 1'b0;
  bit prev_start = 1'b0;
  int dbl = 0;
  int sbusy = 0;
  int ready_bad = 0;

  // I2C master model; all its input changes happen on the falling edge
  always @(negedge clk) begin
    logic st;
    logic [7:0] dat;
    cyc++;
    st  = i2c_start;
    dat = i2c_data;
    if (cmd_ready && !init_done) ready_bad++;
    if (!rst_n) begin
      pend = 0; bcnt = 0; prev_start = 1'b0; i2c_done = 1'b0;
      if (!hold_busy) i2c_busy = 1'b0;
    end else begin
      if (st && prev_start) dbl++;
      if (st && i2c_busy) sbusy++;
      prev_start = st;
      i2c_done = 1'b0;
      if (!hold_busy) begin
        if (pend != 0) begin
          pend = 0; i2c_busy = 1'b1; bcnt = 6;
        end else if (i2c_busy) begin
          bcnt--;
          if (bcnt == 0) begin
            i2c_busy = 1'b0; i2c_done = 1'b1; dq.push_back(cyc);
          end
        end
      end
      if (st) begin
        wq.push_back(dat); sq.push_back(cyc);
        if (!hold_busy) pend = 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearq();
    wq.delete(); sq.delete(); dq.delete();
  endtask

  function automatic int wq_at(input int i);
    return (wq.size() > i) ? int'(wq[i]) : -1;
  endfunction
  function automatic int sq_at(input int i);
    return (sq.size() > i) ? sq[i] : -1000;
  endfunction
  function automatic int dq_at(input int i);
    return (dq.size() > i) ? dq[i] : -1000;
  endfunction

  task automatic wait_writes(input int n, input int budget, input string nm);
    int k = 0;
    while (wq.size() < n && k < budget) begin tick(); k++; end
    chk({nm, " write count"}, (wq.size() >= n) ? n : wq.size(), n);
  endtask

  task automatic wait_ready(input int budget, input string nm, output int lbl);
    int k = 0;
    while (!cmd_ready && k < budget) begin tick(); k++; end
    lbl = cyc;
    chk({nm, " ready"}, int'(cmd_ready), 1);
  endtask

  task automatic do_cmd(input logic rs, input logic [7:0] d, output int acc);
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
    chk("ready drop after accept", int'(cmd_ready), 0);
  endtask

  logic [7:0] init_exp [24] = '{
    8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
    8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
    8'h0C, 8'h08, 8'h1C, 8'h18, 8'h0C, 8'h08, 8'h6C, 8'h68};
  int bnd_idx [7] = '{1, 3, 5, 7, 11, 15, 19};
  int bnd_dly [7] = '{TL, TS, TS, TC, TC, TC, TCL};

  // full power-up + init check, relative to the cycle rst_n was released
  task automatic init_check(input int rel, input string tag);
    int r;
    wait_writes(24, 800, tag);
    cmd_valid = 1'b0;
    chk({tag, " powerup quiet >=20"}, int'((sq_at(0) - rel) >= TP), 1);
    for (int i = 0; i < 24; i++)
      chk($sformatf("%s init write %0d", tag, i), wq_at(i), int'(init_exp[i]));
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s init delay after write %0d", tag, bnd_idx[i]),
          sq_at(bnd_idx[i] + 1) - dq_at(bnd_idx[i]) - 1, bnd_dly[i]);
    wait_ready(100, tag, r);
    chk({tag, " init_done"}, int'(init_done), 1);
    chk({tag, " final gap"}, r - dq_at(23) - 1, TC);
  endtask

  task automatic run_vec(input vec_t v, input int idx, input bit chk_lat);
    int acc, r;
    logic [7:0] exp_b [4];
    exp_b[0] = v.b0; exp_b[1] = v.b1; exp_b[2] = v.b2; exp_b[3] = v.b3;
    clearq();
    do_cmd(v.rs, v.data, acc);
    if (chk_lat) chk($sformatf("vec%0d start latency", idx), sq_at(0), acc + 1);
    wait_writes(4, 100, $sformatf("vec%0d", idx));
    wait_ready(100, $sformatf("vec%0d", idx), r);
    for (int j = 0; j < 4; j++)
      chk($sformatf("vec%0d write %0d", idx, j), wq_at(j), int'(exp_b[j]));
    chk($sformatf("vec%0d gap", idx), r - dq_at(3) - 1, v.gap);
  endtask

  vec_t vt [6];

  initial begin
    int rel, acc, r, chg, lbl, bad;
    logic [7:0] d0;

    vt[0] = '{rs:1'b1, data:8'h48, b0:8'h4D, b1:8'h49, b2:8'h8D, b3:8'h89, gap:TC};
    vt[1] = '{rs:1'b0, data:8'h01, b0:8'h0C, b1:8'h08, b2:8'h1C, b3:8'h18, gap:TCL};
    vt[2] = '{rs:1'b0, data:8'h02, b0:8'h0C, b1:8'h08, b2:8'h2C, b3:8'h28, gap:TCL};
    vt[3] = '{rs:1'b0, data:8'h03, b0:8'h0C, b1:8'h08, b2:8'h3C, b3:8'h38, gap:TCL};
    vt[4] = '{rs:1'b0, data:8'h04, b0:8'h0C, b1:8'h08, b2:8'h4C, b3:8'h48, gap:TC};
    vt[5] = '{rs:1'b1, data:8'h01, b0:8'h0D, b1:8'h09, b2:8'h1D, b3:8'h19, gap:TC};

    // a byte offered throughout init must be held off, never taken
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h41;
    repeat (3) tick();
    chk("reset cmd_ready", int'(cmd_ready), 0);
    chk("reset i2c_start", int'(i2c_start), 0);
    chk("reset i2c_data", int'(i2c_data), 0);
    chk("reset init_done", int'(init_done), 0);

    clearq();
    rst_n = 1'b1;
    rel = cyc;
    init_check(rel, "init1");

    for (int i = 0; i < 6; i++) run_vec(vt[i], i, (i == 0));

    // master held busy with a request pending
    hold_busy = 1'b1; i2c_busy = 1'b1;
    clearq();
    do_cmd(1'b1, 8'h48, acc);
    d0 = i2c_data;
    chg = 0;
    repeat (50) begin
      tick();
      if (i2c_data != d0) chg++;
    end
    chk("hold data value", int'(d0), 8'h4D);
    chk("hold data stable", chg, 0);
    chk("hold no start", sq.size(), 0);
    @(posedge clk);
    #1;
    hold_busy = 1'b0; i2c_busy = 1'b0;
    lbl = cyc + 1;
    wait_writes(4, 100, "hold");
    wait_ready(100, "hold", r);
    chk("hold start on busy drop", sq_at(0), lbl);
    chk("hold write 0", wq_at(0), 8'h4D);
    chk("hold write 3", wq_at(3), 8'h89);

    // reset in the middle of a byte
    clearq();
    do_cmd(1'b1, 8'h48, acc);
    wait_writes(2, 50, "midreset");
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midreset cmd_ready", int'(cmd_ready), 0);
    chk("midreset i2c_start", int'(i2c_start), 0);
    chk("midreset i2c_data", int'(i2c_data), 0);
    chk("midreset init_done", int'(init_done), 0);
    tick(); tick();
    clearq();
    rst_n = 1'b1;
    rel = cyc;
    init_check(rel, "init2");

    // stray done while idle
    clearq();
    i2c_done = 1'b1;
    tick();
    bad = 0;
    repeat (20) begin
      tick();
      if (!cmd_ready) bad++;
    end
    chk("spurious done ready kept", bad, 0);
    chk("spurious done no start", sq.size(), 0);
    run_vec(vt[0], 6, 1'b1);

    chk("start longer than one cycle", dbl, 0);
    chk("start while busy", sbusy, 0);
    chk("ready before init_done", ready_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
